event_timestamper_mt: RTL and testbench

Multi-outcome successor to the per-ID event timestamper. It captures a start timestamp per event ID and pairs it with a later end event to form a latency record. Unlike the first generation, it buffers records in a parametrised output FIFO with true valid/ready backpressure, retires stale IDs with a timeout sweeper, and reports orphan ends instead of stalling on them. It sits between the packet event taps and the record drain/UDP formatter.

---
 rtl/event_ts_pkg.sv | 27 ++
 rtl/ts_record_fifo.sv | 75 +++++++
 rtl/event_timestamper_mt.sv | 149 ++++++++++++++
 tb/tb_event_timestamper_mt.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/event_ts_pkg.sv
// Shared types and constants for the multi-outcome event timestamper.
// The record struct documents the default-width record layout used on the output.
package event_ts_pkg;

    localparam int STATUS_W = 2;
    localparam int PKG_ID_W = 4;
    localparam int PKG_TS_W = 64;

    typedef enum logic [STATUS_W-1:0] {
        ST_OK      = 2'd0,
        ST_TIMEOUT = 2'd1,
        ST_ORPHAN  = 2'd2
    } status_e;

    typedef struct packed {
        logic [PKG_ID_W-1:0] id;
        status_e             status;
        logic [PKG_TS_W-1:0] startTs;
        logic [PKG_TS_W-1:0] endTs;
        logic [PKG_TS_W-1:0] diff;
    } ts_record_t;

    function automatic int recordWidth(input int idW, input int tsW);
        return idW + STATUS_W + 3 * tsW;
    endfunction

endpackage

// File: rtl/ts_record_fifo.sv
// Synchronous first-word-fall-through FIFO whose head word is held in a register.
// The capacity includes the head word, so full means DEPTH records are stored.
module ts_record_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rdPtr_q, rdPtr_d;
    logic [AW-1:0]    wrPtr_q, wrPtr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             valid_q;
    logic             doPush, doPop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = !valid_q;
    assign rdata_o = head_q;

    // The next head is either a stored entry or, when the FIFO drains to it, the word written now.
    always_comb begin
        doPush  = push_i && !full_o;
        doPop   = pop_i && valid_q;
        rdPtr_d = rdPtr_q + AW'(doPop);
        wrPtr_d = wrPtr_q + AW'(doPush);
        count_d = count_q;
        if (doPush && !doPop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!doPush && doPop) begin
            count_d = count_q - (AW+1)'(1);
        end
        head_d = head_q;
        if (count_d != '0) begin
            if (doPush && (count_q == (AW+1)'(doPop))) begin
                head_d = wdata_i;
            end else begin
                head_d = mem_q[rdPtr_d];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
            head_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
            count_q <= count_d;
            head_q  <= head_d;
            valid_q <= (count_d != '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/event_timestamper_mt.sv
// Per-ID start/end latency timestamper with orphan reporting, timeout sweeping
// and a backpressured record FIFO toward the record drain.
module event_timestamper_mt
    import event_ts_pkg::*;
#(
    parameter int ID_W       = 4,
    parameter int TS_W       = 64,
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_valid_i,
    output logic                start_ready_o,
    input  logic [ID_W-1:0]     start_id_i,
    input  logic                end_valid_i,
    output logic                end_ready_o,
    input  logic [ID_W-1:0]     end_id_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [ID_W-1:0]     out_id_o,
    output logic [STATUS_W-1:0] out_status_o,
    output logic [TS_W-1:0]     out_start_ts_o,
    output logic [TS_W-1:0]     out_end_ts_o,
    output logic [TS_W-1:0]     out_ts_o,
    output logic [ID_W:0]       inflight_o
);

    localparam int NID = 2 ** ID_W;
    localparam int REC_W = recordWidth(ID_W, TS_W);
    localparam logic [TS_W-1:0] TIMEOUT_TS = TS_W'(TIMEOUT);

    logic [TS_W-1:0]  cnt_q;
    logic [NID-1:0]   scoreValid_q, scoreValid_d;
    logic [TS_W-1:0]  startTs_q [NID];
    logic [ID_W-1:0]  sweepPtr_q, sweepPtr_d;
    logic [ID_W:0]    inflight_q, inflight_d;

    logic             fifoFull, fifoEmpty;
    logic             startFire, endFire, endHit;
    logic [TS_W-1:0]  sweepDiff;
    logic             sweepCand, sweepRetire;
    logic             pushRec;
    logic [ID_W-1:0]  recId;
    status_e          recStatus;
    logic [TS_W-1:0]  recStart, recEnd, recDiff;
    logic [REC_W-1:0] recData, fifoRdata;

    // An end on the same ID wins the cycle; the start retries once the slot is free.
    assign end_ready_o   = !fifoFull;
    assign endFire       = end_valid_i && !fifoFull;
    assign endHit        = scoreValid_q[end_id_i];
    assign start_ready_o = !scoreValid_q[start_id_i] && !(endFire && (end_id_i == start_id_i));
    assign startFire     = start_valid_i && start_ready_o;

    assign sweepDiff   = cnt_q - startTs_q[sweepPtr_q];
    assign sweepCand   = (TIMEOUT != 0) && scoreValid_q[sweepPtr_q] && (sweepDiff >= TIMEOUT_TS);
    assign sweepRetire = sweepCand && !fifoFull && !endFire && (end_id_i != sweepPtr_q);

    // End events own the FIFO write port; the sweeper only uses idle cycles.
    always_comb begin
        pushRec   = 1'b0;
        recId     = end_id_i;
        recStatus = ST_OK;
        recStart  = '0;
        recEnd    = cnt_q;
        recDiff   = '0;
        if (endFire) begin
            pushRec = 1'b1;
            if (endHit) begin
                recStart = startTs_q[end_id_i];
                recDiff  = cnt_q - startTs_q[end_id_i];
            end else begin
                recStatus = ST_ORPHAN;
            end
        end else if (sweepRetire) begin
            pushRec   = 1'b1;
            recId     = sweepPtr_q;
            recStatus = ST_TIMEOUT;
            recStart  = startTs_q[sweepPtr_q];
            recDiff   = sweepDiff;
        end
    end

    assign recData = {recId, recStatus, recStart, recEnd, recDiff};

    always_comb begin
        scoreValid_d = scoreValid_q;
        if (startFire) begin
            scoreValid_d[start_id_i] = 1'b1;
        end
        if (endFire && endHit) begin
            scoreValid_d[end_id_i] = 1'b0;
        end
        if (sweepRetire) begin
            scoreValid_d[sweepPtr_q] = 1'b0;
        end
        sweepPtr_d = sweepPtr_q;
        if ((TIMEOUT != 0) && !(sweepCand && !sweepRetire)) begin
            sweepPtr_d = sweepPtr_q + ID_W'(1);
        end
        inflight_d = inflight_q;
        if (startFire && !((endFire && endHit) || sweepRetire)) begin
            inflight_d = inflight_q + (ID_W+1)'(1);
        end else if (!startFire && ((endFire && endHit) || sweepRetire)) begin
            inflight_d = inflight_q - (ID_W+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q        <= '0;
            scoreValid_q <= '0;
            sweepPtr_q   <= '0;
            inflight_q   <= '0;
        end else begin
            cnt_q        <= cnt_q + TS_W'(1);
            scoreValid_q <= scoreValid_d;
            sweepPtr_q   <= sweepPtr_d;
            inflight_q   <= inflight_d;
        end
    end

    // Start timestamps need no reset; the valid bits decide whether they mean anything.
    always_ff @(posedge clk_i) begin
        if (startFire) begin
            startTs_q[start_id_i] <= cnt_q;
        end
    end

    ts_record_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (pushRec),
        .wdata_i (recData),
        .pop_i   (out_ready_i),
        .rdata_o (fifoRdata),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty)
    );

    assign out_valid_o = !fifoEmpty;
    assign {out_id_o, out_status_o, out_start_ts_o, out_end_ts_o, out_ts_o} = fifoRdata;
    assign inflight_o  = inflight_q;

endmodule

// File: tb/tb_event_timestamper_mt.sv
// Directed bench for event_timestamper_mt: pairing, orphans, hazards, backpressure,
// timeout sweeping, counter wrap and mid-operation reset.
module tb_event_timestamper_mt;

    localparam int ID_W       = 4;
    localparam int TS_W       = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int TIMEOUT    = 100;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            startValid = 1'b0;
    logic            startReady;
    logic [ID_W-1:0] startId = '0;
    logic            endValid = 1'b0;
    logic            endReady;
    logic [ID_W-1:0] endId = '0;
    logic            outValid;
    logic            outReady = 1'b0;
    logic [ID_W-1:0] outId;
    logic [1:0]      outStatus;
    logic [TS_W-1:0] outStartTs, outEndTs, outTs;
    logic [ID_W:0]   inflight;

    int total = 0;
    int bad = 0;
    int curCnt = 0;

    event_timestamper_mt #(
        .ID_W       (ID_W),
        .TS_W       (TS_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_valid_i  (startValid),
        .start_ready_o  (startReady),
        .start_id_i     (startId),
        .end_valid_i    (endValid),
        .end_ready_o    (endReady),
        .end_id_i       (endId),
        .out_valid_o    (outValid),
        .out_ready_i    (outReady),
        .out_id_o       (outId),
        .out_status_o   (outStatus),
        .out_start_ts_o (outStartTs),
        .out_end_ts_o   (outEndTs),
        .out_ts_o       (outTs),
        .inflight_o     (inflight)
    );

    always #5 clk = ~clk;

    // One clock; afterwards curCnt equals the DUT counter value for the current cycle.
    task automatic step();
        @(negedge clk);
        curCnt++;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        startValid = 1'b0;
        endValid = 1'b0;
        outReady = 1'b0;
        startId = '0;
        endId = '0;
        @(negedge clk);
        rst = 1'b0;
        curCnt = 0;
    endtask

    task automatic popOne();
        outReady = 1'b1;
        step();
        outReady = 1'b0;
    endtask

    task automatic test_reset();
        doReset();
        total++; if (outValid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid got=%0d want=0", outValid); end
        total++; if (outId !== 4'd0) begin bad++; $display("[TB] FAIL reset_out_id got=%0d want=0", outId); end
        total++; if (outStatus !== 2'd0) begin bad++; $display("[TB] FAIL reset_out_status got=%0d want=0", outStatus); end
        total++; if ({outStartTs, outEndTs, outTs} !== 24'd0) begin bad++; $display("[TB] FAIL reset_out_ts got=%0d/%0d/%0d want=0", outStartTs, outEndTs, outTs); end
        total++; if (inflight !== 5'd0) begin bad++; $display("[TB] FAIL reset_inflight got=%0d want=0", inflight); end
        total++; if (startReady !== 1'b1 || endReady !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready got=%0d/%0d want=1/1", startReady, endReady); end
    endtask

    task automatic test_basic_pair();
        while (curCnt < 10) step();
        startValid = 1'b1; startId = 4'd3;
        #1;
        total++; if (startReady !== 1'b1) begin bad++; $display("[TB] FAIL basic_start_ready got=%0d want=1", startReady); end
        step();
        startValid = 1'b0;
        total++; if (inflight !== 5'd1) begin bad++; $display("[TB] FAIL basic_inflight_open got=%0d want=1", inflight); end
        while (curCnt < 25) step();
        endValid = 1'b1; endId = 4'd3;
        step();
        endValid = 1'b0;
        total++; if (outValid !== 1'b1) begin bad++; $display("[TB] FAIL basic_out_valid got=%0d want=1", outValid); end
        total++; if (outId !== 4'd3 || outStatus !== 2'd0) begin bad++; $display("[TB] FAIL basic_id_status got=%0d/%0d want=3/0", outId, outStatus); end
        total++; if (outStartTs !== 8'd10 || outEndTs !== 8'd25) begin bad++; $display("[TB] FAIL basic_start_end got=%0d/%0d want=10/25", outStartTs, outEndTs); end
        total++; if (outTs !== 8'd15) begin bad++; $display("[TB] FAIL basic_latency got=%0d want=15", outTs); end
        total++; if (inflight !== 5'd0) begin bad++; $display("[TB] FAIL basic_inflight_closed got=%0d want=0", inflight); end
        popOne();
        total++; if (outValid !== 1'b0) begin bad++; $display("[TB] FAIL basic_drained got=%0d want=0", outValid); end
    endtask

    task automatic test_orphan();
        logic [TS_W-1:0] expEnd;
        expEnd = TS_W'(curCnt);
        endValid = 1'b1; endId = 4'd7;
        step();
        endValid = 1'b0;
        total++; if (outValid !== 1'b1 || outId !== 4'd7) begin bad++; $display("[TB] FAIL orphan_valid_id got=%0d/%0d want=1/7", outValid, outId); end
        total++; if (outStatus !== 2'd2) begin bad++; $display("[TB] FAIL orphan_status got=%0d want=2", outStatus); end
        total++; if (outStartTs !== 8'd0 || outEndTs !== expEnd || outTs !== 8'd0) begin bad++; $display("[TB] FAIL orphan_ts got=%0d/%0d/%0d want=0/%0d/0", outStartTs, outEndTs, outTs, expEnd); end
        total++; if (inflight !== 5'd0) begin bad++; $display("[TB] FAIL orphan_inflight got=%0d want=0", inflight); end
        popOne();
    endtask

    task automatic test_hazard();
        logic [TS_W-1:0] a;
        a = TS_W'(curCnt);
        startValid = 1'b1; startId = 4'd2;
        step();
        endValid = 1'b1; endId = 4'd2;
        #1;
        total++; if (startReady !== 1'b0 || endReady !== 1'b1) begin bad++; $display("[TB] FAIL hazard_ready got=%0d/%0d want=0/1", startReady, endReady); end
        step();
        endValid = 1'b0;
        total++; if (outStatus !== 2'd0 || outId !== 4'd2) begin bad++; $display("[TB] FAIL hazard_rec_id got=%0d/%0d want=0/2", outStatus, outId); end
        total++; if (outStartTs !== a || outEndTs !== TS_W'(a + 8'd1) || outTs !== 8'd1) begin bad++; $display("[TB] FAIL hazard_rec_ts got=%0d/%0d/%0d want=%0d/%0d/1", outStartTs, outEndTs, outTs, a, a + 8'd1); end
        #1;
        total++; if (startReady !== 1'b1) begin bad++; $display("[TB] FAIL hazard_retry_ready got=%0d want=1", startReady); end
        step();
        startValid = 1'b0;
        total++; if (inflight !== 5'd1) begin bad++; $display("[TB] FAIL hazard_inflight got=%0d want=1", inflight); end
        popOne();
        endValid = 1'b1; endId = 4'd2;
        step();
        endValid = 1'b0;
        popOne();
        total++; if (inflight !== 5'd0 || outValid !== 1'b0) begin bad++; $display("[TB] FAIL hazard_cleanup got=%0d/%0d want=0/0", inflight, outValid); end
    endtask

    task automatic test_back_to_back();
        int accepted;
        logic fired;
        logic [TS_W-1:0] expTs;
        doReset();
        for (int i = 0; i < 5; i++) begin
            startValid = 1'b1; startId = ID_W'(i);
            step();
        end
        startValid = 1'b0;
        total++; if (inflight !== 5'd5) begin bad++; $display("[TB] FAIL bp_inflight got=%0d want=5", inflight); end
        for (int i = 0; i < 4; i++) begin
            endValid = 1'b1; endId = ID_W'(i);
            #1;
            total++; if (endReady !== 1'b1) begin bad++; $display("[TB] FAIL bp_fill_ready id=%0d got=%0d want=1", i, endReady); end
            step();
        end
        endId = 4'd4;
        #1;
        total++; if (endReady !== 1'b0) begin bad++; $display("[TB] FAIL bp_full_ready got=%0d want=0", endReady); end
        step();
        total++; if (outValid !== 1'b1 || outId !== 4'd0 || endReady !== 1'b0) begin bad++; $display("[TB] FAIL bp_hold got=%0d/%0d/%0d want=1/0/0", outValid, outId, endReady); end
        outReady = 1'b1;
        accepted = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            expTs = (i < 4) ? 8'd5 : 8'd7;
            total++; if (outValid !== 1'b1 || outId !== ID_W'(i) || outTs !== expTs) begin bad++; $display("[TB] FAIL bp_drain_order slot=%0d got=%0d/%0d/%0d want=1/%0d/%0d", i, outValid, outId, outTs, i, expTs); end
            if (i == 0) begin
                total++; if (endReady !== 1'b0) begin bad++; $display("[TB] FAIL bp_pop_no_free got=%0d want=0", endReady); end
            end
            fired = endValid && endReady;
            step();
            if (fired) begin
                endValid = 1'b0;
                accepted++;
            end
        end
        outReady = 1'b0;
        total++; if (accepted !== 1) begin bad++; $display("[TB] FAIL bp_id4_accept got=%0d want=1", accepted); end
        total++; if (outValid !== 1'b0 || inflight !== 5'd0) begin bad++; $display("[TB] FAIL bp_final got=%0d/%0d want=0/0", outValid, inflight); end
    endtask

    task automatic test_timeout();
        int waited;
        doReset();
        startValid = 1'b1; startId = 4'd5;
        step();
        startValid = 1'b0;
        waited = 0;
        while (!outValid && waited < 200) begin
            step();
            waited++;
        end
        total++; if (outValid !== 1'b1) begin bad++; $display("[TB] FAIL timeout_seen got=%0d want=1 after %0d cycles", outValid, waited); end
        total++; if (outId !== 4'd5 || outStatus !== 2'd1) begin bad++; $display("[TB] FAIL timeout_id_status got=%0d/%0d want=5/1", outId, outStatus); end
        total++; if (outTs < 8'd100 || outTs > 8'd116) begin bad++; $display("[TB] FAIL timeout_range got=%0d want=100..116", outTs); end
        total++; if (outStartTs !== 8'd0 || outEndTs !== 8'd101 || outTs !== 8'd101 || curCnt !== 102) begin bad++; $display("[TB] FAIL timeout_exact got=%0d/%0d/%0d at %0d want=0/101/101 at 102", outStartTs, outEndTs, outTs, curCnt); end
        total++; if (inflight !== 5'd0) begin bad++; $display("[TB] FAIL timeout_inflight got=%0d want=0", inflight); end
        popOne();
        startValid = 1'b1; startId = 4'd5;
        #1;
        total++; if (startReady !== 1'b1) begin bad++; $display("[TB] FAIL timeout_restart_ready got=%0d want=1", startReady); end
        step();
        startValid = 1'b0;
        total++; if (inflight !== 5'd1) begin bad++; $display("[TB] FAIL timeout_restart_inflight got=%0d want=1", inflight); end
    endtask

    task automatic test_wrap_reset();
        doReset();
        while (curCnt < 250) step();
        startValid = 1'b1; startId = 4'd1;
        step();
        startValid = 1'b0;
        while (curCnt < 261) step();
        endValid = 1'b1; endId = 4'd1;
        step();
        endValid = 1'b0;
        total++; if (outStartTs !== 8'd250 || outEndTs !== 8'd5 || outTs !== 8'd11) begin bad++; $display("[TB] FAIL wrap_ts got=%0d/%0d/%0d want=250/5/11", outStartTs, outEndTs, outTs); end
        popOne();
        for (int i = 8; i < 11; i++) begin
            startValid = 1'b1; startId = ID_W'(i);
            step();
        end
        startValid = 1'b0;
        for (int i = 12; i < 14; i++) begin
            endValid = 1'b1; endId = ID_W'(i);
            step();
        end
        endValid = 1'b0;
        total++; if (inflight !== 5'd3 || outValid !== 1'b1) begin bad++; $display("[TB] FAIL prereset_state got=%0d/%0d want=3/1", inflight, outValid); end
        doReset();
        total++; if (outValid !== 1'b0 || inflight !== 5'd0) begin bad++; $display("[TB] FAIL midreset_clear got=%0d/%0d want=0/0", outValid, inflight); end
        startValid = 1'b1; startId = 4'd8;
        #1;
        total++; if (startReady !== 1'b1) begin bad++; $display("[TB] FAIL midreset_slot_free got=%0d want=1", startReady); end
        step();
        startValid = 1'b0;
        while (curCnt < 3) step();
        endValid = 1'b1; endId = 4'd8;
        step();
        endValid = 1'b0;
        total++; if (outStatus !== 2'd0 || outStartTs !== 8'd0 || outEndTs !== 8'd3 || outTs !== 8'd3) begin bad++; $display("[TB] FAIL fresh_start got=%0d/%0d/%0d/%0d want=0/0/3/3", outStatus, outStartTs, outEndTs, outTs); end
    endtask

    initial begin
        test_reset();
        test_basic_pair();
        test_orphan();
        test_hazard();
        test_back_to_back();
        test_timeout();
        test_wrap_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

endmodule
